// File: rtl/level1_pkg.sv
// Shared defaults for the serial key-lock block.
package level1_pkg;

  localparam int unsigned WIDTH_DEFAULT       = 64;
  localparam logic [63:0] KEY_DEFAULT         = 64'h39C3_ADF0_E798_E1BC;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  // Width of a saturating counter that must be able to hold the value w.
  function automatic int unsigned cnt_bits(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/level1_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, followed by a
// one-flop rising-edge detector on the synchronized level.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the raw pin through the synchronizer chain; remember the last synced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign dout = chain[SYNC_STAGES-1];
  assign rise = dout & ~prev;

endmodule

// File: rtl/level1.sv
// Serial key-lock: each synchronized rising edge of 'shift' clocks the
// synchronized 'd' bit into a shift register (MSB first). led1 shows a
// live match against KEY once a full key's worth of bits has arrived;
// led2 latches the first match until reset.
module level1
  import level1_pkg::*;
#(
  parameter int unsigned      WIDTH       = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] KEY         = KEY_DEFAULT,
  parameter int unsigned      SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift,
  input  logic d,
  output logic led1,
  output logic led2
);

  localparam int unsigned     CW   = cnt_bits(WIDTH);
  localparam logic [CW-1:0]   FULL = CW'(WIDTH);

  logic             shift_pulse;
  logic             shift_lvl_unused;
  logic             d_sync;
  logic             d_rise_unused;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    count;
  logic             led1_next;

  // Strobe path: synchronizer plus edge detect gives one pulse per rise.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_shift_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (shift),
    .dout  (shift_lvl_unused),
    .rise  (shift_pulse)
  );

  // Data path: same depth as the strobe so d_sync lines up with shift_pulse.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_d_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (d),
    .dout  (d_sync),
    .rise  (d_rise_unused)
  );

  // Shift register and saturating bit counter advance on each shift pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg  <= '0;
      count <= '0;
    end else if (shift_pulse) begin
      sreg <= {sreg[WIDTH-2:0], d_sync};
      if (count != FULL) begin
        count <= count + 1'b1;
      end
    end
  end

  // Match is only meaningful once the register has been fully filled since reset.
  always_comb begin
    led1_next = (count == FULL) && (sreg == KEY);
  end

  // Registered indicators: led1 follows the match, led2 remembers it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led1 <= 1'b0;
      led2 <= 1'b0;
    end else begin
      led1 <= led1_next;
      led2 <= led2 | led1_next;
    end
  end

endmodule

// File: tb/tb_level1.sv
// Scoreboard bench for the serial key-lock block.
module tb_level1;

  localparam int unsigned SS  = 2;
  localparam logic [63:0] KEY = 64'h39C3_ADF0_E798_E1BC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic shift = 1'b0;
  logic d     = 1'b0;
  logic led1;
  logic led2;

  level1 #(.WIDTH(64), .KEY(KEY), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (shift),
    .d     (d),
    .led1  (led1),
    .led2  (led2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    at;
    logic  l1;
    logic  l2;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model: history of bits accepted since reset, newest last.
  bit hist[$];
  int nbits  = 0;
  bit m_led2 = 1'b0;

  function automatic bit model_match();
    logic [63:0] v;
    if (nbits < 64) return 1'b0;
    v = '0;
    for (int i = 0; i < 64; i++) v = {v[62:0], hist[hist.size() - 64 + i]};
    return v == KEY;
  endfunction

  function automatic void model_push(input bit b);
    hist.push_back(b);
    if (hist.size() > 64) void'(hist.pop_front());
    nbits++;
    m_led2 = m_led2 | model_match();
  endfunction

  function automatic void expect_at(input int at, input bit l1, input bit l2, input string nm);
    exp_t e;
    e.at = at; e.l1 = l1; e.l2 = l2; e.name = nm;
    exp_q.push_back(e);
  endfunction

  // Monitor: pops every expectation that has come due and compares the LEDs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        if (led1 !== e.l1 || led2 !== e.l2) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: led1/led2 got %b%b, expected %b%b",
                   e.name, cyc, led1, led2, e.l1, e.l2);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    hist.delete();
    nbits  = 0;
    m_led2 = 1'b0;
    expect_at(cyc + 1, 1'b0, 1'b0, "in_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // One shift: d set up early, shift held high for 'hold' clocks, then low.
  task automatic shift_bit(input bit b, input int hold, input string nm);
    int r;
    bit o1, o2;
    @(posedge clk); #1 d = b;
    repeat (SS + 1) @(posedge clk);
    #1 shift = 1'b1;
    r  = cyc;
    o1 = model_match();
    o2 = m_led2;
    model_push(b);
    expect_at(r + SS + 1, o1, o2, {nm, "_pre"});
    expect_at(r + SS + 2, model_match(), m_led2, {nm, "_post"});
    if (hold > SS + 2) expect_at(r + hold, model_match(), m_led2, {nm, "_held"});
    repeat (hold) @(posedge clk);
    #1 shift = 1'b0;
    repeat (SS + 2) @(posedge clk);
  endtask

  task automatic shift_word(input logic [63:0] w, input int nb, input string nm);
    logic [63:0] t;
    t = w;
    for (int i = 63; i > 63 - nb; i--) shift_bit(t[i], SS + 2, nm);
  endtask

  initial begin
    logic [63:0] bad;
    int          nrand;
    do_reset();

    // Key shifted in, then three zeros break the match; led2 sticks.
    shift_word(KEY, 64, "key");
    for (int i = 0; i < 3; i++) shift_bit(1'b0, SS + 2, "extra0");

    // Key with one flipped bit never matches.
    do_reset();
    bad = KEY ^ (64'd1 << 40);
    shift_word(bad, 64, "badkey");

    // Reset mid-sequence discards the partial key.
    do_reset();
    shift_word(KEY, 32, "half");
    do_reset();
    shift_word(KEY, 64, "afterrst");

    // Zeros, a short glitch, and a long-held shift: LEDs stay dark.
    do_reset();
    for (int i = 0; i < 64; i++) shift_bit(1'b0, SS + 2, "zeros");
    @(posedge clk); #1 d = 1'b0;
    repeat (SS + 1) @(posedge clk);
    #1 shift = 1'b1;
    repeat (2) @(posedge clk);
    #1 shift = 1'b0;
    repeat (SS + 3) @(posedge clk);
    expect_at(cyc + 1, 1'b0, 1'b0, "glitch");
    shift_bit(1'b0, 100, "longhi0");

    // Long-held final key bit must count exactly once.
    do_reset();
    shift_word(KEY, 63, "key63");
    shift_bit(KEY[0], 100, "longhikey");

    // Random garbage prefill then key: older bits fall off the end.
    do_reset();
    for (int i = 0; i < 8; i++) shift_bit(1'($urandom), SS + 2, "garb8");
    shift_word(KEY, 64, "garbkey");

    // Long random run past counter range, then key, then random tail.
    do_reset();
    nrand = int'($urandom_range(100, 160));
    for (int i = 0; i < nrand; i++) shift_bit(1'($urandom), SS + 2 + int'($urandom_range(0, 2)), "rnd");
    shift_word(KEY, 64, "rndkey");
    for (int i = 0; i < 5; i++) shift_bit(1'($urandom), SS + 2, "rndtail");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
